// File: rtl/ppu_reg_port.sv
// CPU-facing PPU register port: $2000-$2007 decode (mirrored), VRAM/OAM pointers, $2007 read buffer.
// Define OAM_DMA_EN to build the stalling OAM DMA engine; otherwise DMA_REG is not decoded.
module ppu_reg_port #(
  parameter int          VADDR_W    = 14,
  parameter int          OAM_AW     = 8,
  parameter int          INC_STRIDE = 32,
  parameter logic [15:0] REG_BASE   = 16'h2000,
  parameter logic [15:0] REG_SPAN   = 16'h2000,
  parameter logic [15:0] DMA_REG    = 16'h4014
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_data_in,
  output logic [7:0]         cpu_data_out,
  input  logic               cpu_write_en,
  input  logic               cpu_read_en,
  output logic               cpu_stall,
  output logic [7:0]         ppu_ctrl1,
  output logic [7:0]         ppu_ctrl2,
  input  logic [7:0]         ppu_status,
  output logic               vblank_clr,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic [VADDR_W-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic               vram_re,
  input  logic [7:0]         vram_rdata,
  output logic [OAM_AW-1:0]  oam_addr,
  output logic [7:0]         oam_wdata,
  output logic               oam_we,
  input  logic [7:0]         oam_rdata,
  output logic [15:0]        dma_rd_addr,
  output logic               dma_rd_en,
  input  logic [7:0]         dma_rd_data
);

  localparam logic [16:0] WIN_LO = {1'b0, REG_BASE};
  localparam logic [16:0] WIN_HI = {1'b0, REG_BASE} + {1'b0, REG_SPAN};

  logic               ctrl1_reg;
  logic [7:0]         ctrl1_val_reg;
  logic [7:0]         ctrl2_reg;
  logic [7:0]         scroll_x_reg;
  logic [7:0]         scroll_y_reg;
  logic [7:0]         t_hi_reg;
  logic [VADDR_W-1:0] vram_addr_reg;
  logic [VADDR_W-1:0] vram_addr_next;
  logic [7:0]         read_buf_reg;
  logic               re_pend_reg;
  logic [OAM_AW-1:0]  oam_addr_reg;
  logic               w_reg;
  logic [7:0]         last_wr_reg;
  logic               vblank_clr_reg;

  logic               stall_int;
  logic               dma_wr_phase;
  logic               in_win;
  logic [2:0]         reg_idx;
  logic               wr_ok;
  logic               rd_ok;
  logic [7:0]         wr_hit;
  logic [7:0]         rd_hit;
  logic [VADDR_W-1:0] vram_step;
  logic [15:0]        t_full;
  logic [7:0]         buf_view;
  logic               status_unused;

  assign in_win  = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
  assign reg_idx = cpu_addr[2:0];

  // A write beats a simultaneous read; the stalled CPU is locked out entirely.
  assign wr_ok = cpu_write_en && !stall_int;
  assign rd_ok = cpu_read_en && !cpu_write_en && !stall_int;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign wr_hit[gi] = wr_ok && in_win && (reg_idx == 3'(gi));
      assign rd_hit[gi] = rd_ok && in_win && (reg_idx == 3'(gi));
    end
  endgenerate

  assign vram_step      = ctrl1_val_reg[2] ? VADDR_W'(INC_STRIDE) : VADDR_W'(1);
  assign vram_addr_next = vram_addr_reg + vram_step;
  assign t_full         = {t_hi_reg, cpu_data_in};

  // Forward the in-flight fetch so back-to-back $2007 reads still see the previous byte.
  assign buf_view = re_pend_reg ? vram_rdata : read_buf_reg;

  assign status_unused = ^{ppu_status[4:0], ctrl1_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl1_reg      <= 1'b0;
      ctrl1_val_reg  <= 8'h00;
      ctrl2_reg      <= 8'h00;
      scroll_x_reg   <= 8'h00;
      scroll_y_reg   <= 8'h00;
      t_hi_reg       <= 8'h00;
      vram_addr_reg  <= '0;
      read_buf_reg   <= 8'h00;
      re_pend_reg    <= 1'b0;
      oam_addr_reg   <= '0;
      w_reg          <= 1'b0;
      last_wr_reg    <= 8'h00;
      vblank_clr_reg <= 1'b0;
    end else begin
      vblank_clr_reg <= rd_hit[2];
      re_pend_reg    <= rd_hit[7];
      ctrl1_reg      <= 1'b0;

      if (re_pend_reg) begin
        read_buf_reg <= vram_rdata;
      end

      if (wr_ok && in_win) begin
        last_wr_reg <= cpu_data_in;
      end

      if (wr_hit[0]) begin
        ctrl1_val_reg <= cpu_data_in;
      end
      if (wr_hit[1]) begin
        ctrl2_reg <= cpu_data_in;
      end

      // w is shared by $2005 and $2006 and cleared by a status read.
      if (rd_hit[2]) begin
        w_reg <= 1'b0;
      end else if (wr_hit[5] || wr_hit[6]) begin
        w_reg <= ~w_reg;
      end

      if (wr_hit[5]) begin
        if (w_reg) begin
          scroll_y_reg <= cpu_data_in;
        end else begin
          scroll_x_reg <= cpu_data_in;
        end
      end

      if (wr_hit[6] && !w_reg) begin
        t_hi_reg <= cpu_data_in;
      end

      if (wr_hit[6] && w_reg) begin
        vram_addr_reg <= t_full[VADDR_W-1:0];
      end else if (wr_hit[7] || rd_hit[7]) begin
        vram_addr_reg <= vram_addr_next;
      end

      if (dma_wr_phase) begin
        oam_addr_reg <= oam_addr_reg + 1'b1;
      end else if (wr_hit[3]) begin
        oam_addr_reg <= OAM_AW'(cpu_data_in);
      end else if (wr_hit[4]) begin
        oam_addr_reg <= oam_addr_reg + 1'b1;
      end
    end
  end

  always_comb begin
    cpu_data_out = 8'h00;
    if (in_win) begin
      case (reg_idx)
        3'd0:    cpu_data_out = ctrl1_val_reg;
        3'd1:    cpu_data_out = ctrl2_reg;
        3'd2:    cpu_data_out = {ppu_status[7:5], last_wr_reg[4:0]};
        3'd4:    cpu_data_out = oam_rdata;
        3'd7:    cpu_data_out = buf_view;
        default: cpu_data_out = last_wr_reg;
      endcase
    end
  end

`ifdef OAM_DMA_EN
  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_RD   = 2'd1,
    DMA_WR   = 2'd2
  } dma_state_t;

  dma_state_t        dma_state_reg;
  logic [7:0]        dma_page_reg;
  logic [OAM_AW-1:0] dma_cnt_reg;
  logic              dma_rd_en_reg;
  logic              dma_wr_reg;
  logic              dma_busy_reg;
  logic              dma_trig;

  assign dma_trig = cpu_write_en && !dma_busy_reg && (cpu_addr == DMA_REG);

  // One RD/WR pair per byte; strobes are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_state_reg <= DMA_IDLE;
      dma_page_reg  <= 8'h00;
      dma_cnt_reg   <= '0;
      dma_rd_en_reg <= 1'b0;
      dma_wr_reg    <= 1'b0;
      dma_busy_reg  <= 1'b0;
    end else begin
      case (dma_state_reg)
        DMA_IDLE: begin
          if (dma_trig) begin
            dma_state_reg <= DMA_RD;
            dma_page_reg  <= cpu_data_in;
            dma_cnt_reg   <= '0;
            dma_rd_en_reg <= 1'b1;
            dma_busy_reg  <= 1'b1;
          end
        end
        DMA_RD: begin
          dma_state_reg <= DMA_WR;
          dma_rd_en_reg <= 1'b0;
          dma_wr_reg    <= 1'b1;
        end
        DMA_WR: begin
          dma_wr_reg  <= 1'b0;
          dma_cnt_reg <= dma_cnt_reg + 1'b1;
          if (dma_cnt_reg == '1) begin
            dma_state_reg <= DMA_IDLE;
            dma_busy_reg  <= 1'b0;
          end else begin
            dma_state_reg <= DMA_RD;
            dma_rd_en_reg <= 1'b1;
          end
        end
        default: begin
          dma_state_reg <= DMA_IDLE;
          dma_rd_en_reg <= 1'b0;
          dma_wr_reg    <= 1'b0;
          dma_busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign stall_int    = dma_busy_reg;
  assign dma_wr_phase = dma_wr_reg;
  assign cpu_stall    = dma_busy_reg;
  assign dma_rd_en    = dma_rd_en_reg;
  assign dma_rd_addr  = 16'({dma_page_reg, dma_cnt_reg});
`else
  logic dma_unused;

  assign dma_unused   = ^{dma_rd_data, (cpu_addr == DMA_REG)};
  assign stall_int    = 1'b0;
  assign dma_wr_phase = 1'b0;
  assign cpu_stall    = 1'b0;
  assign dma_rd_en    = 1'b0;
  assign dma_rd_addr  = 16'h0000;
`endif

  assign ppu_ctrl1  = ctrl1_val_reg;
  assign ppu_ctrl2  = ctrl2_reg;
  assign scroll_x   = scroll_x_reg;
  assign scroll_y   = scroll_y_reg;
  assign vram_addr  = vram_addr_reg;
  assign vblank_clr = vblank_clr_reg;
  assign oam_addr   = oam_addr_reg;
  assign vram_wdata = cpu_data_in;
  assign vram_we    = wr_hit[7];
  assign vram_re    = rd_hit[7];
  assign oam_we     = wr_hit[4] || dma_wr_phase;
  assign oam_wdata  = dma_wr_phase ? dma_rd_data : cpu_data_in;

endmodule

// File: tb/tb_ppu_reg_port.sv
// Directed bench for ppu_reg_port with VRAM/OAM/CPU-memory models and a queue scoreboard.
module tb_ppu_reg_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic        cpu_stall;
  logic [7:0]  ppu_ctrl1;
  logic [7:0]  ppu_ctrl2;
  logic [7:0]  ppu_status;
  logic        vblank_clr;
  logic [7:0]  scroll_x;
  logic [7:0]  scroll_y;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic [7:0]  vram_rdata = 8'h00;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic [7:0]  oam_rdata;
  logic [15:0] dma_rd_addr;
  logic        dma_rd_en;
  logic [7:0]  dma_rd_data = 8'h00;

  always #5 clk = ~clk;

  ppu_reg_port dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en), .cpu_stall(cpu_stall),
    .ppu_ctrl1(ppu_ctrl1), .ppu_ctrl2(ppu_ctrl2), .ppu_status(ppu_status),
    .vblank_clr(vblank_clr), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
    .vram_rdata(vram_rdata), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .oam_rdata(oam_rdata), .dma_rd_addr(dma_rd_addr), .dma_rd_en(dma_rd_en),
    .dma_rd_data(dma_rd_data)
  );

  function automatic logic [7:0] cpu_mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory models around the port
  logic [7:0] vram_mem [0:16383];
  logic [7:0] oam_mem  [0:255];

  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    if (vram_re) vram_rdata <= vram_mem[vram_addr];
    if (oam_we) oam_mem[oam_addr] <= oam_wdata;
    if (dma_rd_en) dma_rd_data <= cpu_mem(dma_rd_addr);
  end
  assign oam_rdata = oam_mem[oam_addr];

  int vbc_count = 0;
  int stall_count = 0;
  int oam_we_in_rst = 0;
  always @(negedge clk) begin
    if (vblank_clr) vbc_count++;
    if (cpu_stall) stall_count++;
    if (!rst && oam_we) oam_we_in_rst++;
  end

  // Scoreboard
  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          tests = 0;
  int          fails = 0;

  task automatic expect_push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
      end
      if (obs === e) $display("[TB] ok %s = 0x%0h", t, obs);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_push(tag, e);
    check_pop(obs);
  endtask

  task automatic drive_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_data_in = d; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    #1;
  endtask

  task automatic idle_end();
    @(negedge clk);
    cpu_write_en = 1'b0; cpu_read_en = 1'b0; cpu_data_in = 8'h00;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    drive_wr(a, d);
    idle_end();
  endtask

  task automatic rd_exp(input string tag, input logic [15:0] a, input logic [7:0] e);
    @(negedge clk);
    cpu_addr = a; cpu_read_en = 1'b1; cpu_write_en = 1'b0;
    expect_push(tag, {24'h0, e});
    #1;
    check_pop({24'h0, cpu_data_out});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vbc0, st0, n, wr0;
    rst = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00;
    cpu_write_en = 1'b0; cpu_read_en = 1'b0; ppu_status = 8'h5F;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl1", ppu_ctrl1, 0);
    chk("rst_ctrl2", ppu_ctrl2, 0);
    chk("rst_scroll", {scroll_x, scroll_y}, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_strobes", {cpu_stall, vblank_clr, vram_we, vram_re, oam_we, dma_rd_en}, 0);
    chk("rst_dma_rd_addr", dma_rd_addr, 0);
    @(negedge clk); rst = 1'b1;

    // $2006 pair then $2007 write
    bus_wr(16'h2006, 8'h21); bus_wr(16'h2006, 8'h08);
    chk("v2006_addr", vram_addr, 14'h2108);
    drive_wr(16'h2007, 8'h55);
    chk("v2007_we", vram_we, 1);
    chk("v2007_we_addr", vram_addr, 14'h2108);
    chk("v2007_wdata", vram_wdata, 8'h55);
    idle_end();
    chk("v2007_inc1", vram_addr, 14'h2109);

    // Stride 32 with 14-bit wrap
    bus_wr(16'h2000, 8'h04);
    chk("ctrl1_write", ppu_ctrl1, 8'h04);
    rd_exp("ctrl1_read", 16'h2000, 8'h04); idle_end();
    bus_wr(16'h2006, 8'h3F); bus_wr(16'h2006, 8'hF0);
    drive_wr(16'h2007, 8'h11);
    chk("stride_first_addr", vram_addr, 14'h3FF0);
    idle_end();
    drive_wr(16'h2007, 8'h22);
    chk("stride_wrap_addr", vram_addr, 14'h0010);
    idle_end();
    chk("stride_after", vram_addr, 14'h0030);
    bus_wr(16'h2000, 8'h00);

    // Buffered $2007 reads
    bus_wr(16'h2006, 8'h20); bus_wr(16'h2006, 8'h00);
    bus_wr(16'h2007, 8'hAA); bus_wr(16'h2007, 8'hBB); bus_wr(16'h2007, 8'hCC);
    bus_wr(16'h2006, 8'h20); bus_wr(16'h2006, 8'h00);
    rd_exp("rd2007_stale", 16'h2007, 8'h00);
    chk("rd2007_re", vram_re, 1);
    idle_end();
    rd_exp("rd2007_second", 16'h2007, 8'hAA); idle_end();
    rd_exp("rd2007_third", 16'h2007, 8'hBB); idle_end();
    chk("rd2007_addr", vram_addr, 14'h2003);

    // Simultaneous read and write: the write wins
    @(negedge clk);
    cpu_addr = 16'h2007; cpu_data_in = 8'h66; cpu_write_en = 1'b1; cpu_read_en = 1'b1;
    #1;
    chk("rw_both_re", vram_re, 0);
    chk("rw_both_we", vram_we, 1);
    idle_end();
    chk("rw_both_addr", vram_addr, 14'h2004);

    // Shared toggle and status read
    vbc0 = vbc_count;
    bus_wr(16'h2005, 8'h10);
    rd_exp("status_read", 16'h2002, 8'h50);
    idle_end();
    chk("vblank_clr_pulse", vblank_clr, 1);
    bus_wr(16'h2005, 8'h20);
    chk("scroll_x", scroll_x, 8'h20);
    chk("scroll_y_zero", scroll_y, 8'h00);
    chk("vblank_clr_count", vbc_count - vbc0, 1);
    bus_wr(16'h2005, 8'h30);
    chk("scroll_y", scroll_y, 8'h30);

    // OAM port
    bus_wr(16'h2003, 8'h10);
    drive_wr(16'h2004, 8'h77);
    chk("oam_we", oam_we, 1);
    chk("oam_we_addr", oam_addr, 8'h10);
    chk("oam_wdata", oam_wdata, 8'h77);
    idle_end();
    chk("oam_inc", oam_addr, 8'h11);
    bus_wr(16'h2003, 8'h10);
    rd_exp("oam_read", 16'h2004, 8'h77); idle_end();
    chk("oam_read_noinc", oam_addr, 8'h10);
    rd_exp("read2003_last_wr", 16'h2003, 8'h10); idle_end();
    bus_wr(16'h2003, 8'hFF); bus_wr(16'h2004, 8'h12);
    chk("oam_wrap", oam_addr, 8'h00);

    // Mirrors, out-of-window, $2002 write
    bus_wr(16'h3FF9, 8'h3C);
    chk("mirror_ctrl2", ppu_ctrl2, 8'h3C);
    rd_exp("outside_read", 16'h4000, 8'h00); idle_end();
    bus_wr(16'h4000, 8'h80);
    chk("outside_no_ctrl1", ppu_ctrl1, 8'h00);
    bus_wr(16'h1FFF, 8'h99);
    chk("outside_no_vram", vram_addr, 14'h2004);
    bus_wr(16'h2002, 8'h0B);
    rd_exp("w2002_last_wr", 16'h2005, 8'h0B); idle_end();

`ifdef OAM_DMA_EN
    // OAM DMA from page 2 starting at oam_addr 0xFE
    bus_wr(16'h2003, 8'hFE);
    st0 = stall_count;
    drive_wr(16'h4014, 8'h02);
    idle_end();
    chk("dma_stall_start", cpu_stall, 1);
    chk("dma_first_rd", {dma_rd_en, dma_rd_addr}, {1'b1, 16'h0200});
    repeat (20) @(negedge clk);
    bus_wr(16'h4014, 8'h05);
    bus_wr(16'h2003, 8'h00);
    n = 0;
    while (cpu_stall && n < 2000) begin @(negedge clk); n++; end
    chk("dma_done", cpu_stall, 0);
    chk("dma_stall_cycles", stall_count - st0, 512);
    chk("dma_oam_addr_end", oam_addr, 8'hFE);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] oa;
      oa = 8'(8'hFE + i);
      chk($sformatf("dma_byte_%0d", i), oam_mem[oa], cpu_mem(16'h0200 + 16'(i)));
    end

    // Reset in the middle of a DMA
    drive_wr(16'h4014, 8'h03);
    idle_end();
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    wr0 = oam_we_in_rst;
    chk("dma_rst_oam_we", oam_we, 0);
    chk("dma_rst_stall", cpu_stall, 0);
    chk("dma_rst_rd", {dma_rd_en, dma_rd_addr}, 0);
    repeat (3) @(negedge clk);
    chk("dma_rst_no_writes", oam_we_in_rst - wr0, 0);
`else
    drive_wr(16'h4014, 8'h02);
    idle_end();
    chk("nodma_stall", cpu_stall, 0);
    chk("nodma_rd_en", dma_rd_en, 0);
    rd_exp("nodma_read", 16'h4014, 8'h00); idle_end();
    rst = 1'b0;
    #1;
`endif
    chk("rst2_regs", {ppu_ctrl1, ppu_ctrl2, scroll_x, scroll_y}, 0);
    chk("rst2_ptrs", {2'b00, vram_addr, oam_addr}, 0);
    chk("rst2_strobes", {cpu_stall, vblank_clr, vram_we, vram_re, oam_we, dma_rd_en}, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
